dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between the pipeline MEM stage (CPU) and an external

---
 rtl/dmem_arb_pkg.sv | 7 +
 rtl/dmem_arb_if.sv | 40 ++++
 rtl/dmem_arb_starve_ctr.sv | 35 +++
 rtl/dmem_arbiter.sv | 115 +++++++++++
 tb/tb_dmem_arbiter.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state and access owner.
package dmem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT} arb_state_t;
  typedef enum logic       {OWN_CPU, OWN_EXT}      arb_owner_t;

endpackage

// File: rtl/dmem_arb_if.sv
// Bundle of the CPU, EXT and data-memory signals around the arbiter.
// slave: arbiter view. master: requesters plus memory macro view.
interface dmem_arb_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) ();
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic [DATA_W-1:0] ext_rdata;
  logic              ext_gnt;
  logic              mem_wr;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_rd_data;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    input  mem_rd_data,
    output cpu_rdata, cpu_stall, ext_rdata, ext_gnt,
    output mem_wr, mem_rd, mem_addr, mem_wr_data
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    output mem_rd_data,
    input  cpu_rdata, cpu_stall, ext_rdata, ext_gnt,
    input  mem_wr, mem_rd, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/dmem_arb_starve_ctr.sv
// EXT starvation counter: counts IDLE arbitrations EXT lost to the CPU,
// saturating at MAX_WAIT; at MAX_WAIT EXT is forced to win the next one.
// Only compiled with DMEM_ARB_STARVE_GUARD_EN.
`ifdef DMEM_ARB_STARVE_GUARD_EN
module dmem_arb_starve_ctr #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic force_grant
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // clear wins over increment; hold at MAX_WAIT once reached
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && cnt_q != CW'(MAX_WAIT))
      cnt_d = cnt_q + 1'b1;
  end

  // counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign force_grant = (cnt_q == CW'(MAX_WAIT));
endmodule
`endif

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: serialises CPU (MEM stage) and EXT (loader/debug)
// accesses to a single-port memory. Write done at T+1, read done at T+2,
// followed by one IDLE bubble. CPU has fixed priority.
// Optional: DMEM_ARB_STARVE_GUARD_EN forces an EXT grant after MAX_WAIT losses.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input logic      clk,
  input logic      reset,
  dmem_arb_if.slave bus
);
  if (MAX_WAIT < 1) begin : g_bad_cfg
    $error("dmem_arbiter: MAX_WAIT must be >= 1");
  end

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  logic              mem_wr_q, mem_wr_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              ext_gnt_q, ext_gnt_d;

  logic is_idle, force_ext, ext_win, cpu_done;

  assign is_idle = (state_q == IDLE);
  assign ext_win = bus.ext_req && (!bus.cpu_req || force_ext);

`ifdef DMEM_ARB_STARVE_GUARD_EN
  dmem_arb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk         (clk),
    .reset       (reset),
    .inc         (is_idle && bus.cpu_req && bus.ext_req && !force_ext),
    .clr         (is_idle && ext_win),
    .force_grant (force_ext)
  );
`else
  assign force_ext = 1'b0;
`endif

  // next-state: arbitrate in IDLE, strobe in ACCESS, reads wait one more cycle
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_wr_d    = 1'b0;
    mem_rd_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ext_gnt_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ext_win) begin
          state_d     = ACCESS;
          owner_d     = OWN_EXT;
          mem_wr_d    = bus.ext_we;
          mem_rd_d    = !bus.ext_we;
          mem_addr_d  = bus.ext_addr;
          mem_wdata_d = bus.ext_wdata;
          ext_gnt_d   = bus.ext_we;      // EXT write completes in ACCESS
        end else if (bus.cpu_req) begin
          state_d     = ACCESS;
          owner_d     = OWN_CPU;
          mem_wr_d    = bus.cpu_we;
          mem_rd_d    = !bus.cpu_we;
          mem_addr_d  = bus.cpu_addr;
          mem_wdata_d = bus.cpu_wdata;
        end
      end
      ACCESS: begin
        state_d   = mem_rd_q ? RD_WAIT : IDLE;
        ext_gnt_d = mem_rd_q && (owner_q == OWN_EXT);  // EXT read completes in RD_WAIT
      end
      RD_WAIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state and registered memory/grant outputs; reset drops strobes at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ext_gnt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_wr_q    <= mem_wr_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ext_gnt_q   <= ext_gnt_d;
    end
  end

  // CPU done: write in ACCESS or read in RD_WAIT while it owns the memory
  assign cpu_done = (owner_q == OWN_CPU) &&
                    ((state_q == ACCESS && mem_wr_q) || state_q == RD_WAIT);

  assign bus.cpu_stall   = bus.cpu_req && !cpu_done;
  assign bus.cpu_rdata   = (state_q == RD_WAIT && owner_q == OWN_CPU) ? bus.mem_rd_data : '0;
  assign bus.ext_rdata   = (state_q == RD_WAIT && owner_q == OWN_EXT) ? bus.mem_rd_data : '0;
  assign bus.ext_gnt     = ext_gnt_q;
  assign bus.mem_wr      = mem_wr_q;
  assign bus.mem_rd      = mem_rd_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wr_data = mem_wdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a synchronous single-port memory model.
// Unwritten words read as {16'hA5A5, 7'd0, addr}.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  dmem_arb_if #(.ADDR_W(9), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(9), .DATA_W(32), .MAX_WAIT(8)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // memory model: write on mem_wr, read data valid the cycle after mem_rd
  logic [31:0]  mem [512];
  logic [511:0] written = '0;
  always @(posedge clk) begin
    if (bus.mem_wr) begin
      mem[bus.mem_addr]     <= bus.mem_wr_data;
      written[bus.mem_addr] <= 1'b1;
    end
    if (bus.mem_rd)
      bus.mem_rd_data <= written[bus.mem_addr] ? mem[bus.mem_addr]
                                               : {16'hA5A5, 7'd0, bus.mem_addr};
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ext_req = 1'b0; bus.ext_we = 1'b0; bus.ext_addr = '0; bus.ext_wdata = '0;
    #2;
    total++; if (bus.mem_wr !== 1'b0) begin bad++; $display("FAIL rst_mem_wr got=%0h exp=0", bus.mem_wr); end
    total++; if (bus.mem_rd !== 1'b0) begin bad++; $display("FAIL rst_mem_rd got=%0h exp=0", bus.mem_rd); end
    total++; if (bus.ext_gnt !== 1'b0) begin bad++; $display("FAIL rst_ext_gnt got=%0h exp=0", bus.ext_gnt); end
    total++; if (bus.mem_addr !== 9'h000) begin bad++; $display("FAIL rst_mem_addr got=%0h exp=0", bus.mem_addr); end
    total++; if (bus.mem_wr_data !== 32'h0) begin bad++; $display("FAIL rst_mem_wr_data got=%0h exp=0", bus.mem_wr_data); end
    total++; if (bus.cpu_stall !== 1'b1) begin bad++; $display("FAIL rst_stall_follows_req got=%0h exp=1", bus.cpu_stall); end
    bus.cpu_req = 1'b0; #1;
    total++; if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL rst_stall_no_req got=%0h exp=0", bus.cpu_stall); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_cpu_write;
    tick; bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 9'h005; bus.cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    total++; if (bus.cpu_stall !== 1'b1) begin bad++; $display("FAIL wr_stall_T got=%0h exp=1", bus.cpu_stall); end
    total++; if (bus.mem_wr !== 1'b0) begin bad++; $display("FAIL wr_mem_wr_T got=%0h exp=0", bus.mem_wr); end
    tick; @(negedge clk);
    total++; if (bus.mem_wr !== 1'b1 || bus.mem_rd !== 1'b0) begin bad++; $display("FAIL wr_strobe_T1 got=%0h/%0h exp=1/0", bus.mem_wr, bus.mem_rd); end
    total++; if (bus.mem_addr !== 9'h005) begin bad++; $display("FAIL wr_addr got=%0h exp=005", bus.mem_addr); end
    total++; if (bus.mem_wr_data !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_data got=%0h exp=deadbeef", bus.mem_wr_data); end
    total++; if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL wr_stall_T1 got=%0h exp=0", bus.cpu_stall); end
    tick; bus.cpu_req = 1'b0; @(negedge clk);
    total++; if (bus.mem_wr !== 1'b0) begin bad++; $display("FAIL wr_mem_wr_T2 got=%0h exp=0", bus.mem_wr); end
  endtask

  task automatic test_cpu_read;
    tick; bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 9'h005;
    @(negedge clk);
    total++; if (bus.cpu_stall !== 1'b1) begin bad++; $display("FAIL rd_stall_T got=%0h exp=1", bus.cpu_stall); end
    tick; @(negedge clk);
    total++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 9'h005) begin bad++; $display("FAIL rd_strobe_T1 got=%0h@%0h exp=1@005", bus.mem_rd, bus.mem_addr); end
    total++; if (bus.cpu_stall !== 1'b1) begin bad++; $display("FAIL rd_stall_T1 got=%0h exp=1", bus.cpu_stall); end
    tick; @(negedge clk);
    total++; if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL rd_stall_T2 got=%0h exp=0", bus.cpu_stall); end
    total++; if (bus.cpu_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_rdata got=%0h exp=deadbeef", bus.cpu_rdata); end
    total++; if (bus.mem_rd !== 1'b0) begin bad++; $display("FAIL rd_mem_rd_T2 got=%0h exp=0", bus.mem_rd); end
    tick; bus.cpu_req = 1'b0;
  endtask

  task automatic test_priority;
    int gnts = 0;
    tick;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 9'h010;
    bus.ext_req = 1'b1; bus.ext_we = 1'b1; bus.ext_addr = 9'h011; bus.ext_wdata = 32'h1234;
    @(negedge clk); gnts += int'(bus.ext_gnt);
    tick; @(negedge clk); gnts += int'(bus.ext_gnt);
    total++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 9'h010) begin bad++; $display("FAIL pri_cpu_first got=%0h@%0h exp=1@010", bus.mem_rd, bus.mem_addr); end
    tick; @(negedge clk); gnts += int'(bus.ext_gnt);
    total++; if (bus.cpu_stall !== 1'b0 || bus.cpu_rdata !== 32'hA5A50010) begin bad++; $display("FAIL pri_cpu_done got=%0h/%0h exp=0/a5a50010", bus.cpu_stall, bus.cpu_rdata); end
    tick; bus.cpu_req = 1'b0; @(negedge clk); gnts += int'(bus.ext_gnt);
    total++; if (bus.mem_wr !== 1'b0 || bus.mem_rd !== 1'b0) begin bad++; $display("FAIL pri_bubble got=%0h/%0h exp=0/0", bus.mem_wr, bus.mem_rd); end
    tick; @(negedge clk); gnts += int'(bus.ext_gnt);
    total++; if (bus.mem_wr !== 1'b1 || bus.mem_addr !== 9'h011 || bus.mem_wr_data !== 32'h1234) begin bad++; $display("FAIL pri_ext_wr got=%0h@%0h=%0h exp=1@011=1234", bus.mem_wr, bus.mem_addr, bus.mem_wr_data); end
    total++; if (bus.ext_gnt !== 1'b1) begin bad++; $display("FAIL pri_ext_gnt got=%0h exp=1", bus.ext_gnt); end
    tick; bus.ext_req = 1'b0; @(negedge clk); gnts += int'(bus.ext_gnt);
    tick; @(negedge clk); gnts += int'(bus.ext_gnt);
    total++; if (gnts != 1) begin bad++; $display("FAIL pri_gnt_pulses got=%0d exp=1", gnts); end
  endtask

  task automatic test_ext_read;
    tick; bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 9'h011;
    @(negedge clk);
    tick; @(negedge clk);
    total++; if (bus.mem_rd !== 1'b1 || bus.ext_gnt !== 1'b0) begin bad++; $display("FAIL ext_rd_T1 got rd=%0h gnt=%0h exp 1/0", bus.mem_rd, bus.ext_gnt); end
    tick; @(negedge clk);
    total++; if (bus.ext_gnt !== 1'b1 || bus.ext_rdata !== 32'h1234) begin bad++; $display("FAIL ext_rd_T2 got gnt=%0h data=%0h exp 1/1234", bus.ext_gnt, bus.ext_rdata); end
    total++; if (bus.cpu_stall !== 1'b0 || bus.cpu_rdata !== 32'h0) begin bad++; $display("FAIL ext_rd_cpu_side got=%0h/%0h exp=0/0", bus.cpu_stall, bus.cpu_rdata); end
    tick; bus.ext_req = 1'b0; @(negedge clk);
    total++; if (bus.ext_gnt !== 1'b0 || bus.ext_rdata !== 32'h0) begin bad++; $display("FAIL ext_rd_T3 got=%0h/%0h exp=0/0", bus.ext_gnt, bus.ext_rdata); end
  endtask

  task automatic test_reset_mid_access;
    tick; bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 9'h010;
    tick; @(negedge clk);
    total++; if (bus.mem_rd !== 1'b1) begin bad++; $display("FAIL rmid_pre got=%0h exp=1", bus.mem_rd); end
    #2 rst_n = 1'b0; #1;
    total++; if (bus.mem_rd !== 1'b0) begin bad++; $display("FAIL rmid_rd_drop got=%0h exp=0", bus.mem_rd); end
    tick; @(negedge clk);
    total++; if (bus.cpu_stall !== 1'b1 || bus.cpu_rdata !== 32'h0) begin bad++; $display("FAIL rmid_no_done got=%0h/%0h exp=1/0", bus.cpu_stall, bus.cpu_rdata); end
    #1 rst_n = 1'b1;
    tick; @(negedge clk);
    total++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 9'h010) begin bad++; $display("FAIL rmid_reissue got=%0h@%0h exp=1@010", bus.mem_rd, bus.mem_addr); end
    tick; @(negedge clk);
    total++; if (bus.cpu_stall !== 1'b0 || bus.cpu_rdata !== 32'hA5A50010) begin bad++; $display("FAIL rmid_done got=%0h/%0h exp=0/a5a50010", bus.cpu_stall, bus.cpu_rdata); end
    tick; bus.cpu_req = 1'b0;
  endtask

  task automatic test_back_to_back;
    tick; bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 9'h030; bus.cpu_wdata = 32'h1;
    tick; @(negedge clk);
    total++; if (bus.mem_wr !== 1'b1 || bus.mem_addr !== 9'h030) begin bad++; $display("FAIL b2b_wr0 got=%0h@%0h exp=1@030", bus.mem_wr, bus.mem_addr); end
    tick; bus.cpu_addr = 9'h031; bus.cpu_wdata = 32'h2; @(negedge clk);
    total++; if (bus.mem_wr !== 1'b0 || bus.cpu_stall !== 1'b1) begin bad++; $display("FAIL b2b_bubble got=%0h/%0h exp=0/1", bus.mem_wr, bus.cpu_stall); end
    tick; @(negedge clk);
    total++; if (bus.mem_wr !== 1'b1 || bus.mem_addr !== 9'h031 || bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL b2b_wr1 got=%0h@%0h stall=%0h exp=1@031 stall=0", bus.mem_wr, bus.mem_addr, bus.cpu_stall); end
    tick; bus.cpu_req = 1'b0;
  endtask

  task automatic test_starve;
    int first = 0;
    int dones = 0;
    int exp_first, exp_dones;
    bit cpu_fin = 1'b0;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    exp_first = 25; exp_dones = 8;
`else
    exp_first = 0;  exp_dones = 13;
`endif
    tick;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 9'h010;
    bus.ext_req = 1'b1; bus.ext_we = 1'b1; bus.ext_addr = 9'h020; bus.ext_wdata = 32'h55;
    for (int n = 1; n <= 40; n++) begin
      tick; @(negedge clk);
      if (bus.ext_gnt === 1'b1) begin first = n; break; end
      if (bus.cpu_stall === 1'b0) dones++;
    end
    total++; if (first != exp_first) begin bad++; $display("FAIL starve_first_gnt got=%0d exp=%0d", first, exp_first); end
    total++; if (dones != exp_dones) begin bad++; $display("FAIL starve_cpu_dones got=%0d exp=%0d", dones, exp_dones); end
    tick; bus.ext_req = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (bus.cpu_stall === 1'b0) begin cpu_fin = 1'b1; break; end
      tick;
    end
    total++; if (!cpu_fin) begin bad++; $display("FAIL starve_cpu_finish got=timeout exp=done"); end
    tick; bus.cpu_req = 1'b0;
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_cpu_write;
    test_cpu_read;
    test_priority;
    test_ext_read;
    test_reset_mid_access;
    test_back_to_back;
    test_starve;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
